channel_burst_arbiter: RTL and testbench
========================================

// Module: channel_burst_arbiter
// PURPOSE
//  N-input round-robin arbiter/merge for Channels (d/v/a). Grants one requester at a time.
//  Holds the grant for up to MaxBurst back-to-back words, then rotates priority.
//  Output is registered to break the long merge path into the shared consumer.
//  Sits in front of a shared downstream channel, e.g. a DC FIFO feeding the host link.
// PARAMETERS
//  N         4   number of input channels; must be >= 2
//  W         32  data width of every channel
//  MaxBurst  4   max consecutive words per grant; must be >= 1; 1 means pure word-level RR
// PORTS
//  clk    in   1     clock clk
//  reset  in   1     reset reset, asynchronous, active-high
//  in     ChannelArray slave   N x W   requesters: in.d[i], in.v[i], in.a[i] (a driven here)
//  out    Channel      master  W       merged output: out.d, out.v (driven here), out.a
//  stall  in   1     when 1, no word is accepted from any input; registered output still drains
//  grant  out  $clog2(N)  index of the current/last granted input (registered)
//  idle   out  1     1 when state==IDLE and output register empty
// BEHAVIOUR
//  - Transfer rule on any channel: a word moves in the cycle with v==1 && a==1.
//  - Output register: ov_q, od_q. out.v=ov_q, out.d=od_q. load_ok = ~ov_q | out.a (comb).
//  - Accept: in.a[i]=1 iff input i is selected this cycle && in.v[i] && load_ok && ~stall.
//    At most one in.a bit high per cycle (verify one-hot-or-zero). On accept: od_q<=in.d[i], ov_q<=1.
//    If out.a && no accept: ov_q<=0, od_q holds. Latency in->out: 1 cycle.
//    Throughput: 1 word/cycle with out.a held 1.
//  - State: IDLE, HOLD. Registers: ptr (rotating priority base), cur, cnt ($clog2(MaxBurst+1) bits).
//  - IDLE: sel = first i with in.v[i]==1, searching ptr, ptr+1, ..., wrapping mod N.
//    On accept from sel: cur<=sel, grant<=sel, ptr<=(sel+1) mod N (wrap at N-1 -> 0).
//    If MaxBurst>1 -> HOLD with cnt<=1; else stay IDLE.
//  - HOLD: selected input = cur only; other inputs get a=0 even if valid.
//    Accept -> cnt<=cnt+1; if cnt+1==MaxBurst -> IDLE.
//    in.v[cur]==0 -> IDLE (no transfer that cycle; one bubble).
//    Valid but blocked by ~load_ok or stall -> stay HOLD, cnt held.
//  - stall: blocks accepts in both states; state, ptr, cnt frozen; output register drains normally.
//  - in.d of a non-granted input is never sampled; in.v may drop without handshake (no error).
//  - Reset values: ov_q=0, od_q=0, state=IDLE, ptr=0, cur=0, cnt=0, grant=0, idle=1; all in.a=0.
//  - Reset mid-operation: async clear of all state; word in output register is discarded.
//    Burst is abandoned; after release, arbitration restarts from input 0.
//  - Fairness: with all N inputs continuously valid, each gets exactly MaxBurst words per N*MaxBurst transfers.
// STRUCTURE
//  - Shared package channel_arb_pkg: typedef enum {ARB_IDLE, ARB_HOLD} arb_state_t.
//    Also a localparam-style function for the index width.
//  - One sub-module: rr_priority_pick #(N) (input [N-1:0] req, input [$clog2(N)-1:0] base,
//    output [$clog2(N)-1:0] idx, output any); combinational rotating priority encoder.
//  - Top: FSM + counter + output register + in.a decode.
// TESTING
//  1 N=4,MaxBurst=4, all v=1, out.a=1: output order 0x4,1x4,2x4,3x4,0..., one word/cycle,
//    in.a one-hot each cycle.
//  2 MaxBurst=1, in0 and in2 valid, out.a=1: alternates 0,2,0,2; ptr wraps 3->0 correctly.
//  3 Grant in1 HOLD, in1.v drops after 2 words: one bubble, then next valid above 1 wins, grant updates.
//  4 out.a=0 with ov_q=1: in.a all 0, out.d stable; raise out.a: drained word + new word same cycle, no loss/dup.
//  5 stall=1 for 5 cycles mid-burst: no accepts, cnt frozen, pending word drains.
//    After stall=0 the burst completes its remaining count.
//  6 reset asserted mid-burst with ov_q=1: out.v=0, idle=1, grant=0 immediately.
//    First post-reset grant goes to lowest valid index >= 0.

Source files
------------

// File: rtl/channel_arb_pkg.sv
// Shared types and helpers for the channel burst arbiter.
package channel_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/channel_burst_arbiter_pick.sv
// Rotating priority encoder: first set request at or after base, wrapping mod N.
module rr_priority_pick
    import channel_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req_i,
    input  logic [idx_w(N)-1:0]   base_i,
    output logic [idx_w(N)-1:0]   idx_o,
    output logic                  any_o
);

    localparam int IW = idx_w(N);

    logic [IW-1:0] j;

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(base_i) + k) % N);
            if (!any_o && req_i[j]) begin
                idx_o = j;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/channel_burst_arbiter.sv
// N-input round-robin merge with bounded bursts and a registered output stage.
module channel_burst_arbiter
    import channel_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 32,
    parameter int MaxBurst = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0][W-1:0]   in_d_i,
    input  logic [N-1:0]          in_v_i,
    output logic [N-1:0]          in_a_o,
    output logic [W-1:0]          out_d_o,
    output logic                  out_v_o,
    input  logic                  out_a_i,
    input  logic                  stall_i,
    output logic [idx_w(N)-1:0]   grant_o,
    output logic                  idle_o
);

    localparam int IW = idx_w(N);
    localparam int CW = $clog2(MaxBurst + 1);

    arb_state_t    state_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] cur_q;
    logic [IW-1:0] grant_q;
    logic [CW-1:0] cnt_q;
    logic          ov_q;
    logic [W-1:0]  od_q;

    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [IW-1:0] sel;
    logic          sel_v;
    logic          load_ok;
    logic          acc;
    logic [IW-1:0] ptr_d;
    logic [CW-1:0] cnt_d;

    rr_priority_pick #(.N(N)) u_pick (
        .req_i  (in_v_i),
        .base_i (ptr_q),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Inside a burst only the current owner may be served.
    assign sel     = (state_q == ARB_HOLD) ? cur_q : pick_idx;
    assign sel_v   = (state_q == ARB_HOLD) ? in_v_i[cur_q] : pick_any;
    assign load_ok = ~ov_q | out_a_i;
    assign acc     = sel_v & load_ok & ~stall_i & ~reset;
    assign ptr_d   = (sel == IW'(N - 1)) ? '0 : sel + 1'b1;
    assign cnt_d   = cnt_q + 1'b1;

    always_comb begin
        in_a_o = '0;
        if (acc) begin
            in_a_o[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            cur_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
        end else begin
            if (acc) begin
                od_q <= in_d_i[sel];
                ov_q <= 1'b1;
            end else if (out_a_i) begin
                ov_q <= 1'b0;
            end
            unique case (state_q)
                ARB_IDLE: begin
                    if (acc) begin
                        cur_q   <= sel;
                        grant_q <= sel;
                        ptr_q   <= ptr_d;
                        if (MaxBurst > 1) begin
                            state_q <= ARB_HOLD;
                            cnt_q   <= CW'(1);
                        end
                    end
                end
                ARB_HOLD: begin
                    if (acc) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == CW'(MaxBurst)) begin
                            state_q <= ARB_IDLE;
                        end
                    end else if (!stall_i && !in_v_i[cur_q]) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign out_v_o = ov_q;
    assign out_d_o = od_q;
    assign grant_o = grant_q;
    assign idle_o  = (state_q == ARB_IDLE) & ~ov_q;

endmodule

// File: tb/tb_channel_burst_arbiter.sv
// Directed bench for channel_burst_arbiter: vector table plus multi-cycle sequences.
module tb_channel_burst_arbiter;

    logic              clk;
    logic              reset;
    logic [3:0][31:0]  d;

    logic [3:0]  v,  a,  v2, a2;
    logic        st, oa, st2, oa2;
    logic [31:0] od, od2;
    logic        ov, ov2, idl, idl2;
    logic [1:0]  g,  g2;

    int checks;
    int failures;

    channel_burst_arbiter #(.N(4), .W(32), .MaxBurst(4)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .in_d_i  (d),
        .in_v_i  (v),
        .in_a_o  (a),
        .out_d_o (od),
        .out_v_o (ov),
        .out_a_i (oa),
        .stall_i (st),
        .grant_o (g),
        .idle_o  (idl)
    );

    channel_burst_arbiter #(.N(4), .W(32), .MaxBurst(1)) u_dut1 (
        .clk     (clk),
        .reset   (reset),
        .in_d_i  (d),
        .in_v_i  (v2),
        .in_a_o  (a2),
        .out_d_o (od2),
        .out_v_o (ov2),
        .out_a_i (oa2),
        .stall_i (st2),
        .grant_o (g2),
        .idle_o  (idl2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic        st;
        logic        oa;
        logic [3:0]  ea;
        logic        eov;
        logic [31:0] eod;
        logic [1:0]  eg;
        logic        eidle;
    } row_t;

    row_t rows [0:24];

    function automatic row_t mk(input logic rst, input logic [3:0] vv,
                                input logic [3:0] ea, input logic eov,
                                input logic [31:0] eod, input logic [1:0] eg,
                                input logic eidle);
        row_t r;
        r.rst = rst; r.v = vv; r.st = 1'b0; r.oa = 1'b1;
        r.ea = ea; r.eov = eov; r.eod = eod; r.eg = eg; r.eidle = eidle;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        v = '0; v2 = '0; st = 1'b0; st2 = 1'b0; oa = 1'b1; oa2 = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 32'hD0 + 32'(i);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        failures = 0;

        // Burst rotation table: all valid, MaxBurst=4, 0x4,1x4,2x4,3x4,0...
        for (int k = 0; k < 20; k++) begin
            rows[k] = mk(k == 0, 4'hF, 4'(1 << ((k / 4) % 4)), k > 0,
                         (k == 0) ? 32'h0 : 32'hD0 + 32'(((k - 1) / 4) % 4),
                         (k == 0) ? 2'd0 : 2'(((k - 1) / 4) % 4), k == 0);
        end
        // Owner in1 drops valid after 2 words: bubble, then in3 wins.
        rows[20] = mk(1'b1, 4'b1010, 4'b0010, 1'b0, 32'h0,  2'd0, 1'b1);
        rows[21] = mk(1'b0, 4'b1010, 4'b0010, 1'b1, 32'hD1, 2'd1, 1'b0);
        rows[22] = mk(1'b0, 4'b1000, 4'b0000, 1'b1, 32'hD1, 2'd1, 1'b0);
        rows[23] = mk(1'b0, 4'b1000, 4'b1000, 1'b0, 32'hD1, 2'd1, 1'b1);
        rows[24] = mk(1'b0, 4'b1000, 4'b1000, 1'b1, 32'hD3, 2'd3, 1'b0);

        // Reset state, with requests present to prove no accept under reset.
        reset = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 32'hD0 + 32'(i);
        v = 4'hF; v2 = 4'hF; st = 1'b0; st2 = 1'b0; oa = 1'b1; oa2 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_a", 32'(a), 32'h0);
        chk("rst_ov", 32'(ov), 32'h0);
        chk("rst_od", od, 32'h0);
        chk("rst_grant", 32'(g), 32'h0);
        chk("rst_idle", 32'(idl), 32'h1);

        for (int i = 0; i < 25; i++) begin
            if (rows[i].rst) do_reset();
            @(negedge clk);
            v = rows[i].v; st = rows[i].st; oa = rows[i].oa;
            #1;
            chk($sformatf("row%0d_a", i), 32'(a), 32'(rows[i].ea));
            chk($sformatf("row%0d_onehot", i), 32'($countones(a) <= 1), 32'h1);
            chk($sformatf("row%0d_ov", i), 32'(ov), 32'(rows[i].eov));
            chk($sformatf("row%0d_od", i), od, rows[i].eod);
            chk($sformatf("row%0d_grant", i), 32'(g), 32'(rows[i].eg));
            chk($sformatf("row%0d_idle", i), 32'(idl), 32'(rows[i].eidle));
        end

        // MaxBurst=1 with in0 and in2: strict alternation, pointer wraps 3->0.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            v2 = 4'b0101;
            #1;
            chk($sformatf("rr1_a%0d", k), 32'(a2), (k % 2 == 0) ? 32'h1 : 32'h4);
            if (k > 0) begin
                chk($sformatf("rr1_od%0d", k), od2,
                    ((k - 1) % 2 == 0) ? 32'hD0 : 32'hD2);
                chk($sformatf("rr1_g%0d", k), 32'(g2),
                    ((k - 1) % 2 == 0) ? 32'h0 : 32'h2);
            end
        end

        // Backpressure: output held, then drain and reload in the same cycle.
        do_reset();
        oa = 1'b0;
        @(negedge clk);
        v = 4'b0001;
        #1 chk("bp_first_a", 32'(a), 32'h1);
        @(negedge clk);
        #1;
        chk("bp_blk_a", 32'(a), 32'h0);
        chk("bp_ov", 32'(ov), 32'h1);
        chk("bp_od", od, 32'hD0);
        d[0] = 32'hBEEF0000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp_hold_a%0d", k), 32'(a), 32'h0);
            chk($sformatf("bp_hold_od%0d", k), od, 32'hD0);
        end
        oa = 1'b1;
        #1 chk("bp_release_a", 32'(a), 32'h1);
        @(negedge clk);
        #1;
        chk("bp_new_ov", 32'(ov), 32'h1);
        chk("bp_new_od", od, 32'hBEEF0000);

        // Stall mid-burst on in2; remaining two words resume, then in3.
        do_reset();
        @(negedge clk);
        v = 4'b1100;
        #1 chk("st_w1_a", 32'(a), 32'h4);
        @(negedge clk);
        #1 chk("st_w2_a", 32'(a), 32'h4);
        @(negedge clk);
        st = 1'b1;
        #1;
        chk("st_s0_a", 32'(a), 32'h0);
        chk("st_s0_ov", 32'(ov), 32'h1);
        chk("st_s0_od", od, 32'hD2);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("st_s%0d_a", k), 32'(a), 32'h0);
            chk($sformatf("st_s%0d_ov", k), 32'(ov), 32'h0);
        end
        @(negedge clk);
        st = 1'b0;
        #1 chk("st_w3_a", 32'(a), 32'h4);
        @(negedge clk);
        #1 chk("st_w4_a", 32'(a), 32'h4);
        @(negedge clk);
        #1;
        chk("st_next_a", 32'(a), 32'h8);
        chk("st_grant", 32'(g), 32'h2);

        // Asynchronous reset mid-burst, restart from input 0.
        do_reset();
        @(negedge clk);
        v = 4'b1110;
        #1 chk("ar_w1_a", 32'(a), 32'h2);
        @(negedge clk);
        #1 chk("ar_w2_ov", 32'(ov), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("ar_ov", 32'(ov), 32'h0);
        chk("ar_idle", 32'(idl), 32'h1);
        chk("ar_grant", 32'(g), 32'h0);
        chk("ar_a", 32'(a), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("ar_post_a", 32'(a), 32'h2);
        @(negedge clk);
        #1;
        chk("ar_post_grant", 32'(g), 32'h1);
        chk("ar_post_od", od, 32'hD1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
